// File: rtl/mem_stack_ctrl.sv
// LIFO stack controller driving a small single-port memory with a
// combinational read port. Every command is turned into a fixed-length
// memory access. The controller accepts a new command only when it is
// back in IDLE.
module mem_stack_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 6,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PUSH,
  input  logic             POP,
  input  logic             PEEK,
  input  logic             CLEAR,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             VALID,
  output logic             READY,
  output logic             EMPTY,
  output logic             FULL,
  output logic [AW:0]      SP,
  output logic             OVF,
  output logic             UNF,
  output logic [AW-1:0]    MEM_ADR,
  output logic [WIDTH-1:0] MEM_DI,
  output logic             MEM_EN,
  output logic             MEM_WR,
  input  logic [WIDTH-1:0] MEM_DO
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, SWAP_RD} state_t;

  localparam logic [AW:0] SP_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE = (AW+1)'(1);

  state_t state;
  // READ was started by POP (1) or PEEK (0)
  logic   popOp;
  // WRITE is the second half of a SWAP, so SP must not move
  logic   swapOp;

  // Command decode, memory access sequencing and all registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      popOp   <= 1'b0;
      swapOp  <= 1'b0;
      SP      <= '0;
      DOUT    <= '0;
      VALID   <= 1'b0;
      READY   <= 1'b1;
      EMPTY   <= 1'b1;
      FULL    <= 1'b0;
      OVF     <= 1'b0;
      UNF     <= 1'b0;
      MEM_ADR <= '0;
      MEM_DI  <= '0;
      MEM_EN  <= 1'b0;
      MEM_WR  <= 1'b0;
    end else begin
      // Memory enable stays high so the memory's gated clock never glitches
      MEM_EN <= 1'b1;
      VALID  <= 1'b0;
      OVF    <= 1'b0;
      UNF    <= 1'b0;
      case (state)
        IDLE: begin
          if (CLEAR) begin
            SP    <= '0;
            EMPTY <= 1'b1;
            FULL  <= 1'b0;
          end else if (PUSH && POP) begin
            if (EMPTY) begin
              UNF <= 1'b1;
            end else begin
              state   <= SWAP_RD;
              READY   <= 1'b0;
              MEM_ADR <= AW'(SP - SP_ONE);
              MEM_DI  <= DIN;
              swapOp  <= 1'b1;
            end
          end else if (PUSH) begin
            if (FULL) begin
              OVF <= 1'b1;
            end else begin
              state   <= WRITE;
              READY   <= 1'b0;
              MEM_ADR <= AW'(SP);
              MEM_DI  <= DIN;
              MEM_WR  <= 1'b1;
              swapOp  <= 1'b0;
            end
          end else if (POP || PEEK) begin
            if (EMPTY) begin
              UNF <= 1'b1;
            end else begin
              state   <= READ;
              READY   <= 1'b0;
              MEM_ADR <= AW'(SP - SP_ONE);
              popOp   <= POP;
            end
          end
        end
        WRITE: begin
          // The memory captures MEM_DI at this edge
          MEM_WR <= 1'b0;
          state  <= IDLE;
          READY  <= 1'b1;
          if (!swapOp) begin
            SP    <= SP + SP_ONE;
            EMPTY <= 1'b0;
            FULL  <= ((SP + SP_ONE) == SP_MAX);
          end
        end
        READ: begin
          DOUT  <= MEM_DO;
          VALID <= 1'b1;
          state <= IDLE;
          READY <= 1'b1;
          if (popOp) begin
            SP    <= SP - SP_ONE;
            EMPTY <= (SP == SP_ONE);
            FULL  <= 1'b0;
          end
        end
        SWAP_RD: begin
          // Old top goes out, then the latched word overwrites the same slot
          DOUT   <= MEM_DO;
          VALID  <= 1'b1;
          MEM_WR <= 1'b1;
          state  <= WRITE;
        end
        default: begin
          state <= IDLE;
          READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Bench for mem_stack_ctrl: behavioural 6x4 memory, directed vector table,
// plus hand-written sequences for reset-during-write and held PUSH.
module tb_mem_stack_ctrl;

  logic       CLK = 1'b0;
  logic       RST, PUSH, POP, PEEK, CLEAR;
  logic [3:0] DIN, DOUT, MEM_DI, MEM_DO;
  logic       VALID, READY, EMPTY, FULL, OVF, UNF, MEM_EN, MEM_WR;
  logic [3:0] SP;
  logic [2:0] MEM_ADR;

  mem_stack_ctrl #(.WIDTH(4), .DEPTH(6), .AW(3)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .PEEK(PEEK), .CLEAR(CLEAR),
    .DIN(DIN), .DOUT(DOUT), .VALID(VALID), .READY(READY), .EMPTY(EMPTY),
    .FULL(FULL), .SP(SP), .OVF(OVF), .UNF(UNF), .MEM_ADR(MEM_ADR),
    .MEM_DI(MEM_DI), .MEM_EN(MEM_EN), .MEM_WR(MEM_WR), .MEM_DO(MEM_DO)
  );

  always #5 CLK = ~CLK;

  // Memory model: synchronous write, combinational read
  logic [3:0] mem [0:7];
  int wrCount = 0;
  always @(posedge CLK) begin
    if (MEM_EN && MEM_WR) begin
      mem[MEM_ADR] <= MEM_DI;
      wrCount <= wrCount + 1;
    end
  end
  assign MEM_DO = MEM_EN ? mem[MEM_ADR] : 4'h0;

  // {DOUT, VALID, READY, EMPTY, FULL, SP, OVF, UNF, MEM_WR}
  logic [14:0] actBus;
  assign actBus = {DOUT, VALID, READY, EMPTY, FULL, SP, OVF, UNF, MEM_WR};

  typedef struct {
    string       name;
    logic [3:0]  cmd;   // {PUSH, POP, PEEK, CLEAR}
    logic [3:0]  din;
    logic [14:0] exp;
  } vec_t;

  localparam logic [3:0] NO = 4'b0000, PU = 4'b1000, PO = 4'b0100,
                         PE = 4'b0010, CL = 4'b0001, SW = 4'b1100;

  vec_t vecs[$];
  int   nVec = 0;
  int   nBad = 0;

  function automatic vec_t mk(input string nm, input logic [3:0] cmd,
                              input logic [3:0] din, input logic [3:0] dout,
                              input logic [3:0] vref, input logic [3:0] sp,
                              input logic [2:0] ouw);
    vec_t v;
    v.name = nm;
    v.cmd  = cmd;
    v.din  = din;
    v.exp  = {dout, vref, sp, ouw};
    return v;
  endfunction

  task automatic cmpBus(input string nm, input logic [14:0] exp);
    nVec++;
    if (actBus !== exp) begin
      nBad++;
      $display("FAIL %s: {dout,v,r,e,f,sp,ovf,unf,wr} got %h expected %h", nm, actBus, exp);
    end
  endtask

  task automatic cmpVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [3:0] din);
    {PUSH, POP, PEEK, CLEAR} = cmd;
    DIN = din;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int wrBase;

  initial begin
    RST = 1'b1;
    drive(NO, 4'h0);
    for (int i = 0; i < 6; i++) mem[i] = 4'h0;

    // ---- reset state
    step();
    step();
    cmpBus("reset_bus", {4'h0, 4'b0110, 4'd0, 3'b000});
    cmpVal("reset_mem_en", 32'(MEM_EN), 32'h0);
    cmpVal("reset_mem_adr", 32'(MEM_ADR), 32'h0);
    RST = 1'b0;

    // ---- push 3,5,A then pop x3
    vecs.push_back(mk("s1_push3", PU, 4'h3, 4'h0, 4'b0010, 4'd0, 3'b001));
    vecs.push_back(mk("s1_wr3",   NO, 4'h0, 4'h0, 4'b0100, 4'd1, 3'b000));
    vecs.push_back(mk("s1_push5", PU, 4'h5, 4'h0, 4'b0000, 4'd1, 3'b001));
    vecs.push_back(mk("s1_wr5",   NO, 4'h0, 4'h0, 4'b0100, 4'd2, 3'b000));
    vecs.push_back(mk("s1_pushA", PU, 4'hA, 4'h0, 4'b0000, 4'd2, 3'b001));
    vecs.push_back(mk("s1_wrA",   NO, 4'h0, 4'h0, 4'b0100, 4'd3, 3'b000));
    vecs.push_back(mk("s1_pop1",  PO, 4'h0, 4'h0, 4'b0000, 4'd3, 3'b000));
    vecs.push_back(mk("s1_rdA",   NO, 4'h0, 4'hA, 4'b1100, 4'd2, 3'b000));
    vecs.push_back(mk("s1_pop2",  PO, 4'h0, 4'hA, 4'b0000, 4'd2, 3'b000));
    vecs.push_back(mk("s1_rd5",   NO, 4'h0, 4'h5, 4'b1100, 4'd1, 3'b000));
    vecs.push_back(mk("s1_pop3",  PO, 4'h0, 4'h5, 4'b0000, 4'd1, 3'b000));
    vecs.push_back(mk("s1_rd3",   NO, 4'h0, 4'h3, 4'b1110, 4'd0, 3'b000));
    // ---- fill 1..6, overflow, pop, clear
    for (int k = 1; k <= 6; k++) begin
      vecs.push_back(mk($sformatf("s2_push%0d", k), PU, 4'(k), 4'h3,
                        {2'b00, (k == 1), 1'b0}, 4'(k - 1), 3'b001));
      vecs.push_back(mk($sformatf("s2_wr%0d", k), NO, 4'h0, 4'h3,
                        {3'b010, (k == 6)}, 4'(k), 3'b000));
    end
    vecs.push_back(mk("s2_ovf",   PU, 4'h7, 4'h3, 4'b0101, 4'd6, 3'b100));
    vecs.push_back(mk("s2_idle",  NO, 4'h0, 4'h3, 4'b0101, 4'd6, 3'b000));
    vecs.push_back(mk("s2_pop",   PO, 4'h0, 4'h3, 4'b0001, 4'd6, 3'b000));
    vecs.push_back(mk("s2_rd6",   NO, 4'h0, 4'h6, 4'b1100, 4'd5, 3'b000));
    vecs.push_back(mk("s2_clear", CL, 4'h0, 4'h6, 4'b0110, 4'd0, 3'b000));
    // ---- underflow on empty stack
    vecs.push_back(mk("s3_pop_unf",  PO, 4'h0, 4'h6, 4'b0110, 4'd0, 3'b010));
    vecs.push_back(mk("s3_idle1",    NO, 4'h0, 4'h6, 4'b0110, 4'd0, 3'b000));
    vecs.push_back(mk("s3_peek_unf", PE, 4'h0, 4'h6, 4'b0110, 4'd0, 3'b010));
    vecs.push_back(mk("s3_idle2",    NO, 4'h0, 4'h6, 4'b0110, 4'd0, 3'b000));
    vecs.push_back(mk("s3_swap_unf", SW, 4'h5, 4'h6, 4'b0110, 4'd0, 3'b010));
    vecs.push_back(mk("s3_idle3",    NO, 4'h0, 4'h6, 4'b0110, 4'd0, 3'b000));
    // ---- peek and swap on 9,4; commands during busy cycles are ignored
    vecs.push_back(mk("s4_push9", PU, 4'h9, 4'h6, 4'b0010, 4'd0, 3'b001));
    vecs.push_back(mk("s4_wr9",   NO, 4'h0, 4'h6, 4'b0100, 4'd1, 3'b000));
    vecs.push_back(mk("s4_push4", PU, 4'h4, 4'h6, 4'b0000, 4'd1, 3'b001));
    vecs.push_back(mk("s4_wr4",   NO, 4'h0, 4'h6, 4'b0100, 4'd2, 3'b000));
    vecs.push_back(mk("s4_peek",  PE, 4'h0, 4'h6, 4'b0000, 4'd2, 3'b000));
    vecs.push_back(mk("s4_rd4",   NO, 4'h0, 4'h4, 4'b1100, 4'd2, 3'b000));
    vecs.push_back(mk("s4_swap",  SW, 4'hC, 4'h4, 4'b0000, 4'd2, 3'b000));
    vecs.push_back(mk("s4_swrd_ignpop",  PO, 4'h0, 4'h4, 4'b1000, 4'd2, 3'b001));
    vecs.push_back(mk("s4_swwr_ignpush", PU, 4'h7, 4'h4, 4'b0100, 4'd2, 3'b000));
    vecs.push_back(mk("s4_popC",  PO, 4'h0, 4'h4, 4'b0000, 4'd2, 3'b000));
    vecs.push_back(mk("s4_rdC",   NO, 4'h0, 4'hC, 4'b1100, 4'd1, 3'b000));
    vecs.push_back(mk("s4_pop9",  PO, 4'h0, 4'hC, 4'b0000, 4'd1, 3'b000));
    vecs.push_back(mk("s4_rd9",   NO, 4'h0, 4'h9, 4'b1110, 4'd0, 3'b000));

    foreach (vecs[i]) begin
      drive(vecs[i].cmd, vecs[i].din);
      step();
      cmpBus(vecs[i].name, vecs[i].exp);
    end

    // ---- reset during WRITE: memory still takes the word, controller resets
    drive(PU, 4'hB);
    step();
    cmpBus("rst_push_acc", {4'h9, 4'b0010, 4'd0, 3'b001});
    drive(NO, 4'h0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    cmpBus("rst_bus", {4'h0, 4'b0110, 4'd0, 3'b000});
    cmpVal("rst_mem_en", 32'(MEM_EN), 32'h0);
    cmpVal("rst_mem_di", 32'(MEM_DI), 32'h0);
    cmpVal("rst_write_done", 32'(mem[0]), 32'hB);
    drive(PU, 4'h2);
    step();
    cmpBus("rst_push2", {4'h0, 4'b0010, 4'd0, 3'b001});
    cmpVal("rst_mem_en_up", 32'(MEM_EN), 32'h1);
    drive(NO, 4'h0);
    step();
    drive(PO, 4'h0);
    step();
    drive(NO, 4'h0);
    step();
    cmpBus("rst_pop2", {4'h2, 4'b1110, 4'd0, 3'b000});

    // ---- PUSH held for 4 cycles: accepted every other cycle
    wrBase = wrCount;
    drive(PU, 4'hE);
    for (int i = 0; i < 4; i++) begin
      step();
      cmpVal($sformatf("hold_wr_%0d", i), 32'(MEM_WR), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    drive(NO, 4'h0);
    cmpVal("hold_sp", 32'(SP), 32'd2);
    cmpVal("hold_di", 32'(MEM_DI), 32'hE);
    step();
    cmpVal("hold_wrcount", 32'(wrCount - wrBase), 32'd2);

    // ---- CLEAR wins over PUSH
    wrBase = wrCount;
    drive(4'b1001, 4'h5);
    step();
    drive(NO, 4'h0);
    cmpBus("clear_push", {4'h2, 4'b0110, 4'd0, 3'b000});
    step();
    cmpVal("clear_nowrite", 32'(wrCount - wrBase), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
